// File: rtl/umi_host_agent.sv
// Host-side UMI initiator: issues one request at a time and checks the matching response.
// Optional response timeout is built when UMI_HOST_TIMEOUT_EN is defined.
module umi_host_agent #(
    parameter int unsigned     CW       = 32,
    parameter int unsigned     AW       = 64,
    parameter int unsigned     DW       = 128,
    parameter logic [AW-1:0]   HOSTID   = AW'(64'h0000_0000_0001_0000),
    parameter int unsigned     TOCYCLES = 1024
) (
    input  logic          clk,
    input  logic          nreset,
    input  logic          start,
    input  logic [1:0]    op,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    input  logic [2:0]    size,
    input  logic [7:0]    len,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [DW-1:0] rdata,
    output logic          unsolicited,
    output logic          uhost_req_valid,
    input  logic          uhost_req_ready,
    output logic [CW-1:0] uhost_req_cmd,
    output logic [AW-1:0] uhost_req_dstaddr,
    output logic [AW-1:0] uhost_req_srcaddr,
    output logic [DW-1:0] uhost_req_data,
    input  logic          uhost_resp_valid,
    output logic          uhost_resp_ready,
    input  logic [CW-1:0] uhost_resp_cmd,
    input  logic [AW-1:0] uhost_resp_dstaddr,
    input  logic [AW-1:0] uhost_resp_srcaddr,
    input  logic [DW-1:0] uhost_resp_data
);

    localparam logic [1:0] OP_RD  = 2'd0;
    localparam logic [1:0] OP_WR  = 2'd1;
    localparam logic [1:0] OP_PW  = 2'd2;
    localparam logic [1:0] OP_RSV = 2'd3;

    typedef enum logic [1:0] {IDLE, REQ, WAIT, FIN} state_t;

    state_t        state_q, state_n;
    logic [1:0]    op_q;
    logic          load;
    logic          err_n;
    logic [DW-1:0] rdata_n;
    logic          unsol_n;
    logic          req_hs, resp_hs;
    logic          resp_bad;
    logic          timeout;
    logic [4:0]    exp_opc;
    logic          unused_resp;

    function automatic logic [4:0] req_opcode(input logic [1:0] o);
        case (o)
            OP_WR:   return 5'h03;
            OP_PW:   return 5'h05;
            default: return 5'h01;
        endcase
    endfunction

    assign req_hs      = uhost_req_valid & uhost_req_ready;
    assign resp_hs     = uhost_resp_valid & uhost_resp_ready;
    assign exp_opc     = (op_q == OP_RD) ? 5'h02 : 5'h04;
    assign resp_bad    = (uhost_resp_cmd[4:0] != exp_opc) || (uhost_resp_dstaddr != HOSTID);
    assign unused_resp = ^{uhost_resp_srcaddr, uhost_resp_cmd[CW-1:5]};

`ifdef UMI_HOST_TIMEOUT_EN
    localparam int unsigned CNTW = $clog2(TOCYCLES + 1);
    logic [CNTW-1:0] cnt_q;

    // Cycles spent in REQ/WAIT since the request was launched
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= '0;
        end else if (state_q == REQ || state_q == WAIT) begin
            cnt_q <= cnt_q + CNTW'(1);
        end
    end

    assign timeout = (state_q == REQ || state_q == WAIT) && (cnt_q == CNTW'(TOCYCLES - 1));
`else
    // TOCYCLES only matters when the counter is built
    assign timeout = 1'b0 && (TOCYCLES != 0);
`endif

    always_comb begin
        state_n = state_q;
        load    = 1'b0;
        err_n   = err;
        rdata_n = rdata;
        unsol_n = unsolicited;
        case (state_q)
            IDLE: begin
                if (start && op != OP_RSV) begin
                    state_n = REQ;
                    load    = 1'b1;
                end
                if (resp_hs) unsol_n = 1'b1;
            end
            REQ: begin
                if (req_hs) begin
                    if (op_q == OP_PW) begin
                        state_n = FIN;
                        err_n   = 1'b0;
                    end else begin
                        state_n = WAIT;
                    end
                end else if (timeout) begin
                    state_n = FIN;
                    err_n   = 1'b1;
                end
            end
            WAIT: begin
                if (resp_hs) begin
                    state_n = FIN;
                    err_n   = resp_bad;
                    if (op_q == OP_RD) rdata_n = uhost_resp_data;
                end else if (timeout) begin
                    state_n = FIN;
                    err_n   = 1'b1;
                end
            end
            FIN: begin
                state_n = IDLE;
                if (resp_hs) unsol_n = 1'b1;
            end
            default: state_n = IDLE;
        endcase
    end

    // State plus registered status/handshake outputs decoded from the next state
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q          <= IDLE;
            busy             <= 1'b0;
            done             <= 1'b0;
            err              <= 1'b0;
            rdata            <= '0;
            unsolicited      <= 1'b0;
            uhost_req_valid  <= 1'b0;
            uhost_resp_ready <= 1'b1;
        end else begin
            state_q          <= state_n;
            busy             <= (state_n == REQ) || (state_n == WAIT);
            done             <= (state_n == FIN);
            err              <= err_n;
            rdata            <= rdata_n;
            unsolicited      <= unsol_n;
            uhost_req_valid  <= (state_n == REQ);
            uhost_resp_ready <= (state_n != REQ);
        end
    end

    // Request payload captured at launch and held until the handshake
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            op_q              <= OP_RD;
            uhost_req_cmd     <= '0;
            uhost_req_dstaddr <= '0;
            uhost_req_srcaddr <= '0;
            uhost_req_data    <= '0;
        end else if (load) begin
            op_q              <= op;
            uhost_req_cmd     <= CW'({len, size, req_opcode(op)});
            uhost_req_dstaddr <= addr;
            uhost_req_srcaddr <= HOSTID;
            uhost_req_data    <= (op == OP_RD) ? '0 : wdata;
        end
    end

endmodule

// File: tb/tb_umi_host_agent.sv
// Self-checking bench for umi_host_agent: vector table, request/done scoreboard, corner sequences.
module tb_umi_host_agent;

    localparam logic [63:0] HOSTID = 64'h0000_0000_0001_0000;
    localparam logic [1:0]  OP_RD = 2'd0, OP_WR = 2'd1, OP_PW = 2'd2, OP_RSV = 2'd3;

    logic         clk, nreset, start;
    logic [1:0]   op;
    logic [63:0]  addr;
    logic [127:0] wdata;
    logic [2:0]   size;
    logic [7:0]   len;
    logic         busy, done, err, unsolicited;
    logic [127:0] rdata;
    logic         uhost_req_valid, uhost_req_ready;
    logic [31:0]  uhost_req_cmd;
    logic [63:0]  uhost_req_dstaddr, uhost_req_srcaddr;
    logic [127:0] uhost_req_data;
    logic         uhost_resp_valid, uhost_resp_ready;
    logic [31:0]  uhost_resp_cmd;
    logic [63:0]  uhost_resp_dstaddr, uhost_resp_srcaddr;
    logic [127:0] uhost_resp_data;

    umi_host_agent #(.CW(32), .AW(64), .DW(128), .HOSTID(HOSTID), .TOCYCLES(16)) dut (
        .clk(clk), .nreset(nreset), .start(start), .op(op), .addr(addr), .wdata(wdata),
        .size(size), .len(len), .busy(busy), .done(done), .err(err), .rdata(rdata),
        .unsolicited(unsolicited),
        .uhost_req_valid(uhost_req_valid), .uhost_req_ready(uhost_req_ready),
        .uhost_req_cmd(uhost_req_cmd), .uhost_req_dstaddr(uhost_req_dstaddr),
        .uhost_req_srcaddr(uhost_req_srcaddr), .uhost_req_data(uhost_req_data),
        .uhost_resp_valid(uhost_resp_valid), .uhost_resp_ready(uhost_resp_ready),
        .uhost_resp_cmd(uhost_resp_cmd), .uhost_resp_dstaddr(uhost_resp_dstaddr),
        .uhost_resp_srcaddr(uhost_resp_srcaddr), .uhost_resp_data(uhost_resp_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]   op;
        logic [63:0]  addr;
        logic [127:0] wdata;
        logic [2:0]   size;
        logic [7:0]   len;
        logic [4:0]   resp_opc;
        logic         bad_dst;
        logic [31:0]  exp_cmd;
        logic         exp_err;
        logic [127:0] exp_rdata;
    } vec_t;

    typedef struct { logic [31:0] cmd; logic [63:0] dst; logic [127:0] data; } req_exp_t;
    typedef struct { logic err; logic [127:0] rdata; } done_exp_t;

    req_exp_t     exp_req_q[$];
    done_exp_t    exp_done_q[$];
    logic [127:0] mem [logic [63:0]];
    int           tests = 0;
    int           fails = 0;
    req_exp_t     mon_req;
    done_exp_t    mon_done;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        tests++;
        fails++;
        $display("FAIL %s: event not as required", name);
    endtask

    function automatic logic [127:0] mem_rd(input logic [63:0] a);
        return mem.exists(a) ? mem[a] : '0;
    endfunction

    // Scoreboard: pop expectations on request handshakes and on done pulses
    always @(negedge clk) begin
        if (nreset) begin
            if (uhost_req_valid && uhost_req_ready) begin
                if (exp_req_q.size() == 0) fail_now("req_unexpected");
                else begin
                    mon_req = exp_req_q.pop_front();
                    check("req_cmd", 128'(uhost_req_cmd), 128'(mon_req.cmd));
                    check("req_dst", 128'(uhost_req_dstaddr), 128'(mon_req.dst));
                    check("req_src", 128'(uhost_req_srcaddr), 128'(HOSTID));
                    check("req_data", uhost_req_data, mon_req.data);
                end
            end
            if (done) begin
                if (exp_done_q.size() == 0) fail_now("done_unexpected");
                else begin
                    mon_done = exp_done_q.pop_front();
                    check("done_err", 128'(err), 128'(mon_done.err));
                    check("done_rdata", rdata, mon_done.rdata);
                end
            end
        end
    end

    task automatic drive_start(input vec_t v, input logic push_done);
        start = 1'b1; op = v.op; addr = v.addr; wdata = v.wdata; size = v.size; len = v.len;
        exp_req_q.push_back('{cmd: v.exp_cmd, dst: v.addr, data: (v.op == OP_RD) ? 128'h0 : v.wdata});
        if (push_done) exp_done_q.push_back('{err: v.exp_err, rdata: v.exp_rdata});
    endtask

    task automatic run_vec(input vec_t v);
        int n;
        @(posedge clk); #1;
        drive_start(v, 1'b1);
        @(posedge clk); #1;
        start = 1'b0;
        n = 0;
        while (!(uhost_req_valid && uhost_req_ready) && n < 20) begin
            @(posedge clk); #1; n++;
        end
        if (n >= 20) fail_now("req_wait");
        if (v.op != OP_RD) mem[v.addr] = v.wdata;
        @(posedge clk); #1;
        if (v.op != OP_PW) begin
            uhost_resp_valid   = 1'b1;
            uhost_resp_cmd     = {27'h0, v.resp_opc};
            uhost_resp_dstaddr = v.bad_dst ? (HOSTID ^ 64'h1) : HOSTID;
            uhost_resp_srcaddr = v.addr;
            uhost_resp_data    = (v.op == OP_RD) ? mem_rd(v.addr) : 128'h0;
            n = 0;
            while (!uhost_resp_ready && n < 20) begin
                @(posedge clk); #1; n++;
            end
            if (n >= 20) fail_now("resp_wait");
            @(posedge clk); #1;
            uhost_resp_valid = 1'b0;
        end
        n = 0;
        while ((busy || done) && n < 20) begin
            @(posedge clk); #1; n++;
        end
        if (n >= 20) fail_now("done_wait");
        check("done_seen", 128'(exp_done_q.size()), 128'h0);
    endtask

    localparam logic [127:0] D1 = 128'hDEADBEEF;
    localparam logic [127:0] D2 = 128'h1122_3344_5566_7788_99AA_BBCC_DDEE_FF00;
    localparam logic [127:0] D3 = 128'h55;

    vec_t vecs[9];
    vec_t v;

    initial begin
        vecs[0] = '{OP_WR, 64'h100,  D1,      3'd2, 8'd0, 5'h04, 1'b0, 32'h043, 1'b0, 128'h0};
        vecs[1] = '{OP_RD, 64'h100,  128'h0,  3'd2, 8'd0, 5'h02, 1'b0, 32'h041, 1'b0, D1};
        vecs[2] = '{OP_WR, 64'h2000, D2,      3'd4, 8'd3, 5'h04, 1'b0, 32'h383, 1'b0, D1};
        vecs[3] = '{OP_RD, 64'h2000, 128'h0,  3'd4, 8'd3, 5'h02, 1'b0, 32'h381, 1'b0, D2};
        vecs[4] = '{OP_RD, 64'h100,  128'h0,  3'd2, 8'd0, 5'h04, 1'b0, 32'h041, 1'b1, D1};
        vecs[5] = '{OP_RD, 64'h2000, 128'h0,  3'd2, 8'd0, 5'h02, 1'b1, 32'h041, 1'b1, D2};
        vecs[6] = '{OP_WR, 64'h300,  128'h77, 3'd2, 8'd0, 5'h02, 1'b0, 32'h043, 1'b1, D2};
        vecs[7] = '{OP_PW, 64'h400,  D3,      3'd0, 8'd7, 5'h00, 1'b0, 32'h705, 1'b0, D2};
        vecs[8] = '{OP_RD, 64'h400,  128'h0,  3'd0, 8'd7, 5'h02, 1'b0, 32'h701, 1'b0, D3};

        nreset = 1'b0; start = 1'b0; op = '0; addr = '0; wdata = '0; size = '0; len = '0;
        uhost_req_ready = 1'b1; uhost_resp_valid = 1'b0; uhost_resp_cmd = '0;
        uhost_resp_dstaddr = '0; uhost_resp_srcaddr = '0; uhost_resp_data = '0;
        #22;
        check("rst_busy", 128'(busy), 128'h0);
        check("rst_done", 128'(done), 128'h0);
        check("rst_req_valid", 128'(uhost_req_valid), 128'h0);
        check("rst_resp_ready", 128'(uhost_resp_ready), 128'h1);
        check("rst_rdata", rdata, 128'h0);
        check("rst_cmd", 128'(uhost_req_cmd), 128'h0);
        #5 nreset = 1'b1;

        for (int i = 0; i < 9; i++) run_vec(vecs[i]);

        // Reserved op is ignored
        @(posedge clk); #1;
        start = 1'b1; op = OP_RSV;
        @(posedge clk); #1;
        start = 1'b0;
        check("rsv_busy", 128'(busy), 128'h0);
        check("rsv_req_valid", 128'(uhost_req_valid), 128'h0);

        // Posted write stalled by ready low for 5 cycles
        uhost_req_ready = 1'b0;
        v = '{OP_PW, 64'h500, 128'hA5A5, 3'd1, 8'd2, 5'h00, 1'b0, 32'h225, 1'b0, D3};
        @(posedge clk); #1;
        drive_start(v, 1'b1);
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("stall_valid", 128'(uhost_req_valid), 128'h1);
            check("stall_cmd", 128'(uhost_req_cmd), 128'h225);
            check("stall_dst", 128'(uhost_req_dstaddr), 128'h500);
            check("stall_data", uhost_req_data, 128'hA5A5);
            @(posedge clk); #1;
        end
        uhost_req_ready = 1'b1;
        @(posedge clk); #1;
        check("pw_done", 128'(done), 128'h1);
        check("pw_busy", 128'(busy), 128'h0);
        check("pw_req_valid", 128'(uhost_req_valid), 128'h0);
        @(posedge clk); #1;
        check("pw_done_drop", 128'(done), 128'h0);
        check("pw_no_unsol", 128'(unsolicited), 128'h0);

        // Response while idle sets the sticky flag without done
        uhost_resp_valid = 1'b1; uhost_resp_cmd = 32'h2; uhost_resp_dstaddr = HOSTID;
        @(posedge clk); #1;
        uhost_resp_valid = 1'b0;
        check("unsol_set", 128'(unsolicited), 128'h1);
        check("unsol_no_done", 128'(done), 128'h0);
        @(posedge clk); #1;
        check("unsol_no_done2", 128'(done), 128'h0);

        // Reset while the request is stalled in REQ
        uhost_req_ready = 1'b0;
        v = '{OP_WR, 64'h600, 128'h99, 3'd2, 8'd0, 5'h04, 1'b0, 32'h043, 1'b0, D3};
        drive_start(v, 1'b0);
        @(posedge clk); #1;
        start = 1'b0;
        check("req_valid_before_rst", 128'(uhost_req_valid), 128'h1);
        #2 nreset = 1'b0;
        #1;
        check("rst_req_drops_valid", 128'(uhost_req_valid), 128'h0);
        check("rst_clears_unsol", 128'(unsolicited), 128'h0);
        exp_req_q.delete(); exp_done_q.delete();
        @(posedge clk); #3 nreset = 1'b1;
        uhost_req_ready = 1'b1;

        // Reset while waiting for the response
        @(posedge clk); #1;
        v = '{OP_RD, 64'h100, 128'h0, 3'd2, 8'd0, 5'h02, 1'b0, 32'h041, 1'b0, D1};
        drive_start(v, 1'b0);
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        check("wait_busy", 128'(busy), 128'h1);
        check("wait_resp_ready", 128'(uhost_resp_ready), 128'h1);
        #2 nreset = 1'b0;
        #1;
        check("rst_wait_busy", 128'(busy), 128'h0);
        check("rst_wait_req_valid", 128'(uhost_req_valid), 128'h0);
        check("rst_wait_rdata", rdata, 128'h0);
        exp_req_q.delete(); exp_done_q.delete();
        @(posedge clk); #3 nreset = 1'b1;
        @(posedge clk); #1;
        check("post_rst_done", 128'(done), 128'h0);
        run_vec('{OP_RD, 64'h2000, 128'h0, 3'd2, 8'd0, 5'h02, 1'b0, 32'h041, 1'b0, D2});

`ifdef UMI_HOST_TIMEOUT_EN
        // Unanswered read times out 16 cycles after entering REQ
        @(posedge clk); #1;
        v = '{OP_RD, 64'h100, 128'h0, 3'd2, 8'd0, 5'h02, 1'b0, 32'h041, 1'b1, D2};
        drive_start(v, 1'b1);
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            @(posedge clk); #1;
            if (k < 16) check("to_no_done", 128'(done), 128'h0);
            else        check("to_done", 128'(done), 128'h1);
        end
        @(posedge clk); #1;
        uhost_resp_valid = 1'b1; uhost_resp_cmd = 32'h2; uhost_resp_dstaddr = HOSTID;
        @(posedge clk); #1;
        uhost_resp_valid = 1'b0;
        check("to_late_unsol", 128'(unsolicited), 128'h1);
`endif

        @(posedge clk); #1;
        check("queues_drained", 128'(exp_req_q.size() + exp_done_q.size()), 128'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
